// File: rtl/icb_slave_sram.sv
// ICB responder in front of a single-port, word-addressed 32-bit on-chip SRAM.
// Commands are taken at most one per cycle. The address is checked and the
// SRAM is accessed in the command cycle. The result is held in a single stage
// (s1) for one cycle and then pushed into an in-order response FIFO.
// Commands are only accepted while a response slot is guaranteed to be free,
// so the SRAM pipeline never has to stall on response back-pressure.
module icb_slave_sram #(
    parameter int          MEM_AW    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          RSP_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        sram_icb_cmd_valid,
    output logic        sram_icb_cmd_ready,
    input  logic [31:0] sram_icb_cmd_addr,
    input  logic        sram_icb_cmd_read,
    input  logic [31:0] sram_icb_cmd_wdata,
    input  logic [3:0]  sram_icb_cmd_wmask,

    output logic        sram_icb_rsp_valid,
    input  logic        sram_icb_rsp_ready,
    output logic        sram_icb_rsp_err,
    output logic [31:0] sram_icb_rsp_rdata
);

    localparam int          WORDS    = 2 ** MEM_AW;
    localparam int          PTR_W    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int          CNT_W    = $clog2(RSP_DEPTH + 1);
    // One past the last valid byte address. 33 bits wide so that a window
    // ending at the top of the 4 GiB space cannot wrap around.
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(WORDS) << 2);

    // ------------------------------------------------------------------
    // Init flag: keeps cmd_ready low during the first cycle after reset
    // release.
    // ------------------------------------------------------------------
    logic init_reg;

    // Set once, on the first clock edge after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_reg <= 1'b0;
        end else begin
            init_reg <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Credit-based command acceptance
    // ------------------------------------------------------------------
    logic             s1_vld_reg;
    logic             s1_err_reg;
    logic             s1_read_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] used_slots;
    logic             cmd_fire;

    // Every response that is in flight (in s1 or in the FIFO) owns a slot.
    // A pop frees its slot only through cnt_reg, which means one cycle later.
    // That keeps cmd_ready purely registered.
    assign used_slots         = cnt_reg + CNT_W'(s1_vld_reg);
    assign sram_icb_cmd_ready = init_reg & (used_slots < CNT_W'(RSP_DEPTH));
    assign cmd_fire           = sram_icb_cmd_valid & sram_icb_cmd_ready;

    // ------------------------------------------------------------------
    // Address decode, done in the command cycle
    // ------------------------------------------------------------------
    logic              addr_err;
    logic [MEM_AW-1:0] word_idx;
    logic              wr_en;
    logic              rd_en;

    assign addr_err = (sram_icb_cmd_addr[1:0] != 2'b00)
                    | (sram_icb_cmd_addr < BASE_ADDR)
                    | ({1'b0, sram_icb_cmd_addr} >= END_ADDR);
    assign word_idx = MEM_AW'((sram_icb_cmd_addr - BASE_ADDR) >> 2);
    assign wr_en    = cmd_fire & ~sram_icb_cmd_read & ~addr_err;
    assign rd_en    = cmd_fire &  sram_icb_cmd_read & ~addr_err;

    // ------------------------------------------------------------------
    // SRAM: four byte lanes. Each lane is its own array with a registered
    // read, so each one maps onto a plain block RAM with a byte write enable.
    // ------------------------------------------------------------------
    logic [31:0] ram_q;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [0:WORDS-1];
            logic [7:0] lane_q_reg;

            // Byte-lane write on a masked, error-free write; the synchronous read feeds s1.
            always_ff @(posedge clk) begin
                if (wr_en && sram_icb_cmd_wmask[gi]) begin
                    lane_mem[word_idx] <= sram_icb_cmd_wdata[8*gi +: 8];
                end
                if (rd_en) begin
                    lane_q_reg <= lane_mem[word_idx];
                end
            end

            assign ram_q[8*gi +: 8] = lane_q_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage s1: holds the command outcome while the SRAM read completes.
    // ------------------------------------------------------------------
    logic [31:0] s1_rdata;

    // Capture the per-command status. The read data arrives from the SRAM in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_reg  <= 1'b0;
            s1_err_reg  <= 1'b0;
            s1_read_reg <= 1'b0;
        end else begin
            s1_vld_reg  <= cmd_fire;
            s1_err_reg  <= cmd_fire & addr_err;
            s1_read_reg <= cmd_fire & sram_icb_cmd_read;
        end
    end

    // Writes and errored accesses always return zero data.
    assign s1_rdata = (s1_read_reg && !s1_err_reg) ? ram_q : 32'h0;

    // ------------------------------------------------------------------
    // Response FIFO. The head must be visible in the same cycle it becomes
    // valid, so the storage is a small register array with a combinational
    // head read.
    // ------------------------------------------------------------------
    logic [32:0]      fifo_mem [0:RSP_DEPTH-1];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_next;
    logic             fifo_push;
    logic             fifo_pop;
    logic [32:0]      fifo_head;

    assign fifo_push = s1_vld_reg;
    assign fifo_pop  = sram_icb_rsp_valid & sram_icb_rsp_ready;
    assign fifo_head = fifo_mem[rd_ptr_reg];

    // Next pointer and count values. The pointers wrap modulo RSP_DEPTH.
    // A push and a pop in the same cycle leave the count unchanged.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        cnt_next    = cnt_reg;
        if (fifo_push) begin
            wr_ptr_next = (wr_ptr_reg == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
        end
        if (fifo_pop) begin
            rd_ptr_next = (rd_ptr_reg == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
        end
        case ({fifo_push, fifo_pop})
            2'b10:   cnt_next = cnt_reg + CNT_W'(1);
            2'b01:   cnt_next = cnt_reg - CNT_W'(1);
            default: cnt_next = cnt_reg;
        endcase
    end

    // FIFO control state. Reset discards every queued response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            cnt_reg    <= cnt_next;
        end
    end

    // FIFO payload. The credit check guarantees the FIFO is never full when s1 pushes.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr_reg] <= {s1_err_reg, s1_rdata};
        end
    end

    // The response fields are forced to zero while nothing is queued. They
    // are stable under back-pressure because the head only moves on a pop.
    assign sram_icb_rsp_valid = (cnt_reg != '0);
    assign sram_icb_rsp_err   = sram_icb_rsp_valid & fifo_head[32];
    assign sram_icb_rsp_rdata = sram_icb_rsp_valid ? fifo_head[31:0] : 32'h0;

endmodule
